// File: rtl/pattern_search_ctrl.sv
// pattern_search_ctrl
// Data-memory master that counts occurrences of a 5-bit pattern in a
// 32-byte message. Byte 0 is the most significant byte of the bit string.
// It reads the pattern byte first. It then scans the message one byte per
// clock and writes three 8-bit counts back to memory:
//   ctb : matching windows that lie entirely inside one byte
//   cto : bytes holding at least one inside-byte match
//   cts : all matching windows, including those spanning two bytes
// The memory read is combinational. Every read therefore completes in the
// same cycle that presents its address.

module pattern_search_ctrl #(
  parameter int NBYTES   = 32,
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  // Byte index width. It covers 0..NBYTES-1.
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Controller states
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_PAT = 3'd1;
  localparam logic [2:0] S_SCAN     = 3'd2;
  localparam logic [2:0] S_WR_CTB   = 3'd3;
  localparam logic [2:0] S_WR_CTO   = 3'd4;
  localparam logic [2:0] S_WR_CTS   = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [AW-1:0] PAT_A = AW'(PAT_ADDR);
  localparam logic [AW-1:0] CTB_A = AW'(RES_ADDR);
  localparam logic [AW-1:0] CTO_A = AW'(RES_ADDR + 1);
  localparam logic [AW-1:0] CTS_A = AW'(RES_ADDR + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  // Registered state
  logic [2:0]    r_state;
  logic [4:0]    r_pat;    // pattern, taken from bits [7:3] of the pattern byte
  logic [3:0]    r_prev;   // low nibble of the previous byte, for crossing windows
  logic [IW-1:0] r_idx;    // message byte currently on the bus
  logic [7:0]    r_ctb;
  logic [7:0]    r_cto;
  logic [7:0]    r_cts;
  logic          r_done;

  // Per-byte match logic
  logic [11:0]   w_cross;     // previous nibble followed by the current byte
  logic [3:0]    w_in_hits;   // inside-byte windows w0..w3 that match
  logic [3:0]    w_x_hits;    // crossing windows that match
  logic [2:0]    w_m;         // inside-byte match count, 0..4
  logic [2:0]    w_c;         // crossing match count, 0..4
  logic          w_accept;    // start request accepted this cycle

  // Counts set bits in a 4-bit hit vector.
  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // The four crossing windows use the top four bits of the previous byte's
  // low nibble chain: x[11:7], x[10:6], x[9:5], x[8:4].
  assign w_cross = {r_prev, mem_rd_data};

  // Compare every 5-bit window of the current byte (and the byte boundary) against the pattern.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    w_in_hits = '0;
    w_x_hits  = '0;
    for (int i = 0; i < 4; i++) begin
      w_in_hits[i] = (mem_rd_data[i +: 5] == r_pat);
      // Byte 0 has no predecessor, so it has no crossing windows.
      w_x_hits[i]  = (w_cross[11-i -: 5] == r_pat) && (r_idx != '0);
    end
  end

  assign w_m = popcnt4(w_in_hits);
  assign w_c = popcnt4(w_x_hits);

  // A start request is only heard while the block is idle or holding results.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Sequencer: state, pattern, index and the three counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_prev  <= '0;
      r_idx   <= '0;
      r_ctb   <= '0;
      r_cto   <= '0;
      r_cts   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_ctb   <= '0;
            r_cto   <= '0;
            r_cts   <= '0;
            r_idx   <= '0;
            r_prev  <= '0;
            r_done  <= 1'b0;
            r_state <= S_LOAD_PAT;
          end
        end

        S_LOAD_PAT: begin
          r_pat   <= mem_rd_data[7:3];
          r_idx   <= '0;
          r_state <= S_SCAN;
        end

        S_SCAN: begin
          // Counter maxima are 128/32/252, so 8 bits never overflow.
          r_ctb  <= r_ctb + 8'(w_m);
          r_cto  <= r_cto + 8'(w_m != 3'd0);
          r_cts  <= r_cts + 8'(w_m) + 8'(w_c);
          r_prev <= mem_rd_data[3:0];
          r_idx  <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state <= S_WR_CTB;
          end
        end

        S_WR_CTB: r_state <= S_WR_CTO;
        S_WR_CTO: r_state <= S_WR_CTS;

        S_WR_CTS: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus outputs depend on the state only. Reset therefore forces address, data and strobe to zero.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (r_state)
      S_LOAD_PAT: mem_addr = PAT_A;
      S_SCAN:     mem_addr = AW'(r_idx);
      S_WR_CTB: begin
        mem_addr    = CTB_A;
        mem_wr_en   = 1'b1;
        mem_wr_data = r_ctb;
      end
      S_WR_CTO: begin
        mem_addr    = CTO_A;
        mem_wr_en   = 1'b1;
        mem_wr_data = r_cto;
      end
      S_WR_CTS: begin
        mem_addr    = CTS_A;
        mem_wr_en   = 1'b1;
        mem_wr_data = r_cts;
      end
      default: ;
    endcase
  end

  assign done = r_done;
  assign busy = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: doc/pattern_search_ctrl.md
Name:
pattern_search_ctrl

Overview:
- Hardware sequencer for the program-3 workload: 5-bit pattern search over the 32-byte message in data memory.
- On a start pulse it reads the pattern byte (addr 32) and message bytes (addr 0..31) through one data-memory port.
- It computes three counts and writes them to addr 33/34/35, then raises done.
- It sits beside the core as a data-memory master; it provides an accelerated equivalent of program 3.

Parameters:
- NBYTES, 32: message length in bytes; message occupies addr 0..NBYTES-1.
- PAT_ADDR, 32: address of pattern byte; pattern is bits [7:3], bits [2:0] ignored.
- RES_ADDR, 33: base result address. ctb goes to RES_ADDR, cto to RES_ADDR+1, cts to RES_ADDR+2.
- AW, 8: data-memory address width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- done  out  1  high from completion until the next accepted start or reset.
- busy  out  1  high in every state except IDLE and DONE.
- mem_addr  out  AW  data-memory address.
- mem_rd_data  in  8  data-memory read data; combinational (same-cycle) read of mem_addr.
- mem_wr_en  out  1  write strobe; memory writes on the rising edge when high.
- mem_wr_data  out  8  write data.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
  - All counters, the index and the pattern register clear.
  - Applies in any state, including mid-scan. No pending result writes are issued afterwards.
- States: IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE.
- IDLE/DONE:
  - start==1 at edge E0: clear ctb/cto/cts/idx/prev, done<=0, go to LOAD_PAT.
  - start==0: stay; DONE holds done=1.
- LOAD_PAT:
  - mem_addr=PAT_ADDR; at E1 pat<=mem_rd_data[7:3]; go to SCAN with idx=0.
- SCAN:
  - mem_addr=idx; b=mem_rd_data.
  - Within-byte windows: w0=b[4:0], w1=b[5:1], w2=b[6:2], w3=b[7:3]; m = number of wi equal to pat (0..4).
  - At each edge: ctb+=m; cto+=1 if m>0.
  - Crossing windows (only for idx>0): x = {prev[3:0], b} (12 bits); windows x[11:7], x[10:6], x[9:5], x[8:4]; c = number equal to pat.
  - At each edge: cts += m+c; prev<=b; idx+=1.
  - After idx==NBYTES-1 is processed (edge E33) go to WR_CTB.
  - Byte 0 is the most significant byte of the string: 252 windows total, 128 within-byte and 124 crossing.
- WR_CTB / WR_CTO / WR_CTS:
  - Each state lasts one cycle with mem_wr_en=1.
  - Addresses RES_ADDR, RES_ADDR+1, RES_ADDR+2; data ctb, cto, cts.
  - Writes land at E34, E35, E36. The WR_CTS edge (E36) moves to DONE with done<=1.
- Latency: done first high in the cycle after E36, i.e. 36 clocks after the start-sampling edge.
- Width rules:
  - All counters are 8 bits.
  - Maxima are ctb=128, cto=32, cts=252; no saturation is needed.
- Boundary conditions:
  - start held high: accepted once per pass; while busy, start is ignored.
  - start high in DONE: restart; done drops at that edge.
  - Memory is never written outside RES_ADDR..RES_ADDR+2, and never outside the WR states.
  - mem_wr_en is 0 in all other states.

Test Plan:
- All 32 bytes 0x00, pat byte 0x00 -> mem[33]=128, mem[34]=32, mem[35]=252; done rises 36 clocks after the start edge.
- All bytes 0x55, pat byte 0xA8 (10101) -> 64, 32, 126.
- All bytes 0x1F, pat byte 0xF8 (11111) -> 32, 32, 32.
- Byte0=0x0F, byte1=0x80, rest 0x00, pat 11111 -> 0, 0, 1 (crossing-only match).
- Byte31=0xF8, rest 0x00, pat 11111 -> 1, 1, 1. Then pulse start again with no data change -> identical results; counters must not accumulate.
- Reset=0 during SCAN at idx=10 -> IDLE, done=0, busy=0, no writes to 33..35. Extra start pulses during SCAN -> ignored; exactly 3 writes per pass.
